// File: rtl/dft_tpi_profiler.sv
// dft_tpi_profiler: baseline / fault-injected / test-point views of a 16-input AND with saturating hit counters.
// Optional macro OBS_HITS_EN adds an obs_hits counter port.  Rev 1.0
`default_nettype none

module dft_tpi_profiler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_vec,
  input  logic             in_valid,
  input  logic             test_mode,
  input  logic             cp_force_1,
  input  logic             fault_enable,
  input  logic             clr,
  output logic             out_base,
  output logic             out_tpi,
  output logic             obs,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [CNT_W-1:0] base_hits,
  output logic [CNT_W-1:0] tpi_hits
`ifdef OBS_HITS_EN
  ,
  output logic [CNT_W-1:0] obs_hits
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic n_lo;
  logic n_hi;
  logic n_lo_f;
  logic n_hi_c;
  logic base_c;
  logic tpi_c;
  logic obs_c;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + CNT_ONE : v;
  endfunction

  always_comb begin
    n_lo   = &in_vec[7:0];
    n_hi   = &in_vec[15:8];
    base_c = n_lo & n_hi;
    n_lo_f = fault_enable | n_lo;
    n_hi_c = (test_mode & cp_force_1) | n_hi;
    tpi_c  = n_lo_f & n_hi_c;
    obs_c  = test_mode & n_lo_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_base <= 1'b0;
      out_tpi  <= 1'b0;
      obs      <= 1'b0;
    end else if (in_valid) begin
      out_base <= base_c;
      out_tpi  <= tpi_c;
      obs      <= obs_c;
    end
  end

  // clr wins over a coincident increment; output registers are unaffected by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_cnt   <= '0;
      base_hits <= '0;
      tpi_hits  <= '0;
    end else if (clr) begin
      pat_cnt   <= '0;
      base_hits <= '0;
      tpi_hits  <= '0;
    end else if (in_valid) begin
      pat_cnt   <= sat_inc(pat_cnt, 1'b1);
      base_hits <= sat_inc(base_hits, base_c);
      tpi_hits  <= sat_inc(tpi_hits, tpi_c);
    end
  end

`ifdef OBS_HITS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_hits <= '0;
    end else if (clr) begin
      obs_hits <= '0;
    end else if (in_valid) begin
      obs_hits <= sat_inc(obs_hits, obs_c);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dft_tpi_profiler.sv
// tb_dft_tpi_profiler: random and directed checks of dft_tpi_profiler against a rule-level model.
// Two instances share stimulus: CNT_W=16 for profiling, CNT_W=4 for saturation.  Rev 1.0
`default_nettype none

module tb_dft_tpi_profiler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_vec = '0;
  logic        in_valid = 1'b0;
  logic        test_mode = 1'b0;
  logic        cp_force_1 = 1'b0;
  logic        fault_enable = 1'b0;
  logic        clr = 1'b0;

  logic        out_base, out_tpi, obs;
  logic [15:0] pat_cnt, base_hits, tpi_hits;
  logic        out_base4, out_tpi4, obs4;
  logic [3:0]  pat_cnt4, base_hits4, tpi_hits4;
`ifdef OBS_HITS_EN
  logic [15:0] obs_hits;
  logic [3:0]  obs_hits4;
`endif

  int total = 0;
  int bad = 0;

  // model: last registered results plus true (unsaturated) counts since last clear/reset
  logic   m_base, m_tpi, m_obs;
  longint m_pat, m_bh, m_th, m_oh;

  always #5 clk = ~clk;

  dft_tpi_profiler #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .test_mode(test_mode), .cp_force_1(cp_force_1), .fault_enable(fault_enable), .clr(clr),
    .out_base(out_base), .out_tpi(out_tpi), .obs(obs),
    .pat_cnt(pat_cnt), .base_hits(base_hits), .tpi_hits(tpi_hits)
`ifdef OBS_HITS_EN
    , .obs_hits(obs_hits)
`endif
  );

  dft_tpi_profiler #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
    .test_mode(test_mode), .cp_force_1(cp_force_1), .fault_enable(fault_enable), .clr(clr),
    .out_base(out_base4), .out_tpi(out_tpi4), .obs(obs4),
    .pat_cnt(pat_cnt4), .base_hits(base_hits4), .tpi_hits(tpi_hits4)
`ifdef OBS_HITS_EN
    , .obs_hits(obs_hits4)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    m_base = 1'b0; m_tpi = 1'b0; m_obs = 1'b0;
    m_pat = 0; m_bh = 0; m_th = 0; m_oh = 0;
  endtask

  // Expected results straight from the pattern rules, not from the node structure.
  task automatic model_edge();
    logic lo_ok, hi_ok, b, t, o;
    lo_ok = fault_enable || (in_vec[7:0] == 8'hFF);
    hi_ok = (test_mode && cp_force_1) || (in_vec[15:8] == 8'hFF);
    b = (in_vec == 16'hFFFF);
    t = lo_ok && hi_ok;
    o = test_mode && lo_ok;
    if (clr) begin
      m_pat = 0; m_bh = 0; m_th = 0; m_oh = 0;
    end else if (in_valid) begin
      m_pat++; m_bh += longint'(b); m_th += longint'(t); m_oh += longint'(o);
    end
    if (in_valid) begin
      m_base = b; m_tpi = t; m_obs = o;
    end
  endtask

  task automatic step(input logic [15:0] v, input logic val, input logic tm,
                      input logic cp, input logic fe, input logic cl);
    in_vec = v; in_valid = val; test_mode = tm; cp_force_1 = cp; fault_enable = fe; clr = cl;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_base"}, out_base, m_base);
    check({tag, ".out_tpi"}, out_tpi, m_tpi);
    check({tag, ".obs"}, obs, m_obs);
    check({tag, ".pat_cnt"}, pat_cnt, sat(m_pat, 16));
    check({tag, ".base_hits"}, base_hits, sat(m_bh, 16));
    check({tag, ".tpi_hits"}, tpi_hits, sat(m_th, 16));
    check({tag, ".out_base4"}, out_base4, m_base);
    check({tag, ".pat_cnt4"}, pat_cnt4, sat(m_pat, 4));
    check({tag, ".base_hits4"}, base_hits4, sat(m_bh, 4));
    check({tag, ".tpi_hits4"}, tpi_hits4, sat(m_th, 4));
`ifdef OBS_HITS_EN
    check({tag, ".obs_hits"}, obs_hits, sat(m_oh, 16));
    check({tag, ".obs_hits4"}, obs_hits4, sat(m_oh, 4));
`endif
  endtask

  initial begin
    model_reset();

    // reset held while a hitting pattern is presented
    for (int i = 0; i < 3; i++) begin
      step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("reset");
    end
    rst_n = 1'b1;

    // baseline
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("base_ffff");
    check("base_ffff.out_tpi_lit", out_tpi, 1);
    step(16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("base_fffe");
    check("base.pat_lit", pat_cnt, 2);
    check("base.bh_lit", base_hits, 1);
    check("base.th_lit", tpi_hits, 1);

    // fault without CP: cp_force_1 ignored outside test_mode
    step(16'hFF00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("fault_ff00");
    check("fault_ff00.out_tpi_lit", out_tpi, 1);
    step(16'h00FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_all("fault_00ff");
    check("fault_00ff.out_tpi_lit", out_tpi, 0);

    // fault with CP
    step(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_all("clr1");
    for (int i = 0; i < 100; i++) begin
      step(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_all("cp_run");
    end
    check("cp.tpi_hits_lit", tpi_hits, 100);
    check("cp.obs_lit", obs, 1);
    for (int i = 0; i < 5; i++) begin
      step($urandom, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check_all("hold");
    end

    // saturation (4-bit instance) and clear with load
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("sat");
    end
    check("sat.base_hits4_lit", base_hits4, 15);
    check("sat.pat_cnt4_lit", pat_cnt4, 15);
    step(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("clr_load");
    check("clr_load.out_base_lit", out_base4, 1);

    // asynchronous reset mid-run
    for (int i = 0; i < 4; i++) step(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("rst_release");

    // random profile phases
    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      step(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_all("rnd_base");
    end
    check("rnd_base.bh_le2", longint'(base_hits <= 2), 1);

    step(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      step(16'($urandom), 1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
      check_all("rnd_fault");
    end
    check("rnd_fault.th_range", longint'(tpi_hits >= 15 && tpi_hits <= 80), 1);

    step(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      step(16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_all("rnd_cp");
    end
    check("rnd_cp.th_lit", tpi_hits, 10000);

    // everything randomized, including valid and clr
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
      check_all("rnd_mix");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dft_tpi_profiler.md
Name: dft_tpi_profiler

Overview:
- Testability-profiling block for a random-pattern-resistant 16-input AND function.
- Evaluates three views of every applied pattern in parallel:
  - a fault-free baseline output;
  - a fault-injectable copy with one test-point-inserted control point (CP);
  - one observation point (OP).
- Registers the outputs and accumulates saturating hit counters, so a random-pattern bench can compare baseline, faulty and CP-assisted detectability.

Parameters:
- CNT_W, 16, width of the pattern counter and every hit counter (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vec  input  16  test pattern.
- in_valid  input  1  pattern qualifier; 1 = evaluate and count this cycle.
- test_mode  input  1  enables the test points (CP and OP).
- cp_force_1  input  1  CP control; forces the high-half node to 1 when test_mode=1.
- fault_enable  input  1  injects a stuck-at-1 fault on the low-half node.
- clr  input  1  synchronous clear of all counters.
- out_base  output  1  registered baseline function output.
- out_tpi  output  1  registered faulty/TPI function output.
- obs  output  1  registered observation-point output.
- pat_cnt  output  CNT_W  number of valid patterns applied.
- base_hits  output  CNT_W  number of valid patterns with baseline result 1.
- tpi_hits  output  CNT_W  number of valid patterns with TPI result 1.

Behaviour:
- Combinational nodes:
  - n_lo = &in_vec[7:0]
  - n_hi = &in_vec[15:8]
  - base_c = n_lo & n_hi
- Fault site: n_lo_f = fault_enable ? 1 : n_lo. fault_enable acts regardless of test_mode.
- Control point: n_hi_c = (test_mode & cp_force_1) ? 1 : n_hi. cp_force_1 is ignored when test_mode=0.
- tpi_c = n_lo_f & n_hi_c.
- obs_c = test_mode & n_lo_f. The OP taps the post-fault low node and is 0 when test_mode=0.
- Output registers:
  - on a rising clk with in_valid=1: out_base<=base_c, out_tpi<=tpi_c, obs<=obs_c;
  - with in_valid=0: all three hold;
  - latency: one cycle from pattern to output.
- Counters:
  - pat_cnt increments on every valid cycle;
  - base_hits increments on valid cycles with base_c=1;
  - tpi_hits increments on valid cycles with tpi_c=1;
  - every counter saturates at 2^CNT_W-1 and never wraps.
- clr=1:
  - all counters go to 0 on the next edge;
  - clr has priority over a coincident increment, so that pattern is not counted;
  - output registers still load if in_valid=1.
- Reset (rst_n=0, asynchronous): out_base, out_tpi, obs and all counters go to 0 immediately. Release is synchronous to the next clk edge.
- Reset asserted mid-run discards all accumulated counts.
- Control inputs (test_mode, cp_force_1, fault_enable) may change on any cycle and take effect on the pattern sampled in that same cycle.
- Expected random-pattern hit rates:
  - baseline ≈ 1/65536;
  - fault only ≈ 1/256;
  - fault with CP active = 1.

Optional Feature:
- Macro OBS_HITS_EN.
- Defined:
  - adds output port obs_hits (CNT_W wide);
  - obs_hits counts valid cycles with obs_c=1;
  - same saturation, clr and reset rules as the other counters.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 with in_valid=1 and in_vec=16'hFFFF -> all outputs and counters are 0 while reset is held.
- Baseline: fault_enable=0, test_mode=0, in_vec=16'hFFFF valid, then 16'hFFFE valid -> first cycle after: out_base=1, out_tpi=1; second: both 0. base_hits=1, tpi_hits=1, pat_cnt=2.
- Fault, no CP: fault_enable=1, test_mode=0, cp_force_1=1.
  - in_vec=16'hFF00 -> out_tpi=1, out_base=0, obs=0.
  - in_vec=16'h00FF -> out_tpi=0, because the CP is ignored.
- Fault with CP: fault_enable=1, test_mode=1, cp_force_1=1, 100 valid cycles of in_vec=16'h0000 -> out_tpi=1, obs=1, tpi_hits=100, base_hits=0, pat_cnt=100. Holding in_valid=0 afterwards keeps all values unchanged.
- Saturation and clear: CNT_W=4, 20 valid cycles of 16'hFFFF -> base_hits=15, pat_cnt=15. Then clr=1 with in_valid=1 -> all counters 0 and out_base still 1.
- Random profile: 10000 valid $random patterns in each of three phases, clearing counters between phases:
  - baseline: base_hits ≤ 2;
  - fault only: tpi_hits in 15..80;
  - fault with CP: tpi_hits = 10000.
